sha_padder: RTL and testbench

- Upstream message formatter for the SHA-256 round core.
- Accepts a byte-granular message as a stream of 32-bit big-endian words and appends FIPS 180-4 padding: 0x80, zero fill, and the 64-bit bit length.
- Emits 512-bit blocks with the per-block mode code, spaced so the core, which has no ready signal, is never overrun.

---
 rtl/sha_padder.sv | 186 ++++++++++++++++++
 tb/tb_sha_padder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_padder.sv
// sha_padder: formats a byte-granular message into SHA-256 512-bit blocks.
// Appends FIPS 180-4 padding (0x80, zero fill, 64-bit bit length) and paces
// blk_valid so consecutive pulses are at least BLOCK_INTERVAL cycles apart.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  word handshake; in_ready is high only while filling
//   in_data         big-endian message word, first byte in [31:24]
//   in_last         final word of the message
//   in_bytes        valid bytes in the final word (0 means 4)
//   blk_valid       one-cycle block strobe
//   blk_mode        1 = first block of a message, 0 = continuation
//   blk_message     block data, word 0 in [511:480]
//   blk_last        block is the final block of its message
module sha_padder #(
    parameter int unsigned BLOCK_INTERVAL = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    output logic         blk_valid,
    output logic [1:0]   blk_mode,
    output logic [511:0] blk_message,
    output logic         blk_last
);

    typedef enum logic [1:0] {FILL, PAD, EMIT} state_t;

    localparam logic [6:0] GAP_MAX = 7'(BLOCK_INTERVAL - 1);

    state_t        state_q, state_d;
    logic [31:0]   buf_q [16];
    logic [31:0]   buf_d [16];
    logic [3:0]    idx_q, idx_d;
    logic [60:0]   byte_cnt_q, byte_cnt_d;
    logic          first_blk_q, first_blk_d;
    logic          final_q, final_d;
    // 0x80 still owed at buf[idx] (message ended on a word boundary)
    logic          pending_q, pending_d;
    // another PAD pass is needed after the current block is emitted
    logic          pad_owed_q, pad_owed_d;
    logic [6:0]    gap_q, gap_d;
    logic          in_ready_q, in_ready_d;
    logic          blk_valid_q, blk_valid_d;
    logic [1:0]    blk_mode_q, blk_mode_d;
    logic [511:0]  blk_message_q, blk_message_d;
    logic          blk_last_q, blk_last_d;

    logic [31:0]   word;
    logic [2:0]    inc;
    logic [4:0]    used;
    logic [63:0]   bitlen;

    assign bitlen = {byte_cnt_q, 3'b000};

    always_comb begin
        state_d       = state_q;
        buf_d         = buf_q;
        idx_d         = idx_q;
        byte_cnt_d    = byte_cnt_q;
        first_blk_d   = first_blk_q;
        final_d       = final_q;
        pending_d     = pending_q;
        pad_owed_d    = pad_owed_q;
        gap_d         = (gap_q == GAP_MAX) ? gap_q : gap_q + 7'd1;
        blk_valid_d   = 1'b0;
        blk_mode_d    = blk_mode_q;
        blk_message_d = blk_message_q;
        blk_last_d    = blk_last_q;
        word          = in_data;
        inc           = 3'd4;
        used          = {1'b0, idx_q} + {4'd0, pending_q};

        case (state_q)
            FILL: begin
                if (in_valid && in_ready_q) begin
                    if (in_last) begin
                        case (in_bytes)
                            2'd1:    begin word = {in_data[31:24], 8'h80, 16'h0000}; inc = 3'd1; end
                            2'd2:    begin word = {in_data[31:16], 8'h80, 8'h00};    inc = 3'd2; end
                            2'd3:    begin word = {in_data[31:8], 8'h80};            inc = 3'd3; end
                            default: begin word = in_data;                            inc = 3'd4; end
                        endcase
                    end
                    buf_d[idx_q] = word;
                    idx_d        = idx_q + 4'd1;
                    byte_cnt_d   = byte_cnt_q + 61'(inc);
                    pending_d    = in_last && (in_bytes == 2'd0);
                    if (idx_q == 4'd15) begin
                        state_d    = EMIT;
                        final_d    = 1'b0;
                        pad_owed_d = in_last;
                    end else if (in_last) begin
                        state_d = PAD;
                    end
                end
            end

            PAD: begin
                // One pass covers all three padding cases: the marker lands at
                // buf[idx] if still owed, and the length fits only if words
                // 14/15 are free; otherwise a length-only block follows.
                for (int unsigned w = 0; w < 16; w++) begin
                    if (4'(w) >= idx_q) buf_d[4'(w)] = '0;
                end
                if (pending_q) buf_d[idx_q] = 32'h8000_0000;
                pending_d = 1'b0;
                if (used <= 5'd14) begin
                    buf_d[14]  = bitlen[63:32];
                    buf_d[15]  = bitlen[31:0];
                    final_d    = 1'b1;
                    pad_owed_d = 1'b0;
                end else begin
                    final_d    = 1'b0;
                    pad_owed_d = 1'b1;
                end
                state_d = EMIT;
            end

            EMIT: begin
                if (gap_q == GAP_MAX) begin
                    blk_valid_d = 1'b1;
                    blk_mode_d  = first_blk_q ? 2'd1 : 2'd0;
                    blk_last_d  = final_q;
                    for (int unsigned w = 0; w < 16; w++) begin
                        blk_message_d[511 - 32*w -: 32] = buf_q[4'(w)];
                    end
                    first_blk_d = final_q;
                    idx_d       = '0;
                    gap_d       = '0;
                    if (final_q) byte_cnt_d = '0;
                    state_d = (!final_q && pad_owed_q) ? PAD : FILL;
                end
            end

            default: state_d = FILL;
        endcase

        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FILL;
            buf_q         <= '{default: '0};
            idx_q         <= '0;
            byte_cnt_q    <= '0;
            first_blk_q   <= 1'b1;
            final_q       <= 1'b0;
            pending_q     <= 1'b0;
            pad_owed_q    <= 1'b0;
            gap_q         <= GAP_MAX;
            in_ready_q    <= 1'b1;
            blk_valid_q   <= 1'b0;
            blk_mode_q    <= '0;
            blk_message_q <= '0;
            blk_last_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_q         <= buf_d;
            idx_q         <= idx_d;
            byte_cnt_q    <= byte_cnt_d;
            first_blk_q   <= first_blk_d;
            final_q       <= final_d;
            pending_q     <= pending_d;
            pad_owed_q    <= pad_owed_d;
            gap_q         <= gap_d;
            in_ready_q    <= in_ready_d;
            blk_valid_q   <= blk_valid_d;
            blk_mode_q    <= blk_mode_d;
            blk_message_q <= blk_message_d;
            blk_last_q    <= blk_last_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign blk_valid   = blk_valid_q;
    assign blk_mode    = blk_mode_q;
    assign blk_message = blk_message_q;
    assign blk_last    = blk_last_q;

endmodule

// File: tb/tb_sha_padder.sv
// tb_sha_padder: directed bench for sha_padder. Message blocks are compared
// against a byte-level FIPS 180-4 padding reference plus hand-derived words,
// timing and handshake expectations.
module tb_sha_padder;

    localparam int unsigned BI = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [1:0]   in_bytes;
    logic         blk_valid;
    logic [1:0]   blk_mode;
    logic [511:0] blk_message;
    logic         blk_last;

    always #5 clk = ~clk;

    sha_padder #(.BLOCK_INTERVAL(BI)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_bytes   (in_bytes),
        .blk_valid  (blk_valid),
        .blk_mode   (blk_mode),
        .blk_message(blk_message),
        .blk_last   (blk_last)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [511:0] msg;
        logic [1:0]   mode;
        logic         last;
        int           cyc;
    } blk_t;

    blk_t got[$];
    blk_t rec;
    always @(negedge clk) begin
        if (blk_valid) begin
            rec.msg  = blk_message;
            rec.mode = blk_mode;
            rec.last = blk_last;
            rec.cyc  = cyc;
            got.push_back(rec);
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    logic [7:0]   msg[$];
    logic [511:0] exp_blks[$];
    int           last_acc;
    int           prev_cyc = -1;

    function automatic void build(input int len);
        msg.delete();
        for (int i = 0; i < len; i++) msg.push_back(8'((i * 37 + len * 11 + 5) % 256));
    endfunction

    // Plain byte-oriented SHA-256 padding reference.
    function automatic void ref_pad();
        logic [7:0]   p[$];
        logic [63:0]  bl;
        logic [511:0] b;
        p = msg;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        exp_blks.delete();
        for (int n = 0; n < p.size() / 64; n++) begin
            b = '0;
            for (int j = 0; j < 64; j++) b[511 - 8*j -: 8] = p[64*n + j];
            exp_blks.push_back(b);
        end
    endfunction

    // Streams msg; bytes past the end of the last word carry junk (0xA5).
    task automatic send(input bit gaps, input int max_beats);
        int nbeats;
        int guard;
        logic [31:0] w;
        nbeats = (msg.size() + 3) / 4;
        guard  = 0;
        for (int b = 0; b < nbeats && b < max_beats; ) begin
            @(negedge clk);
            in_valid = !(gaps && $urandom_range(0, 2) == 0);
            for (int j = 0; j < 4; j++)
                w[31 - 8*j -: 8] = (4*b + j < msg.size()) ? msg[4*b + j] : 8'hA5;
            in_data  = w;
            in_last  = (b == nbeats - 1);
            in_bytes = 2'(msg.size() % 4);
            if (in_valid && in_ready) begin
                last_acc = cyc + 1;
                b++;
            end
            guard++;
            if (guard > 2000) begin
                n_chk++;
                $display("FAIL send_timeout: beat %0d of %0d never accepted", b, nbeats);
                break;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_blocks(input string name, input int base, input int n);
        int guard;
        guard = 0;
        while (got.size() < base + n && guard < n * BI + 300) begin
            @(negedge clk);
            guard++;
        end
        repeat (4) @(negedge clk);
        check({name, "_count"}, 512'(got.size() - base), 512'(n));
    endtask

    task automatic check_blocks(input string name, input int base);
        for (int k = 0; k < exp_blks.size(); k++) begin
            if (got.size() > base + k) begin
                check($sformatf("%s_blk%0d", name, k), got[base+k].msg, exp_blks[k]);
                check($sformatf("%s_mode%0d", name, k), 512'(got[base+k].mode), 512'((k == 0) ? 1 : 0));
                check($sformatf("%s_last%0d", name, k), 512'(got[base+k].last),
                      512'((k == exp_blks.size() - 1) ? 1 : 0));
                if (prev_cyc >= 0)
                    check($sformatf("%s_spacing%0d", name, k),
                          512'(got[base+k].cyc - prev_cyc >= int'(BI)), 512'(1));
                prev_cyc = got[base+k].cyc;
            end
        end
    endtask

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
    endtask

    typedef struct {
        int          len;
        bit          gaps;
        int          nblk;
        logic [63:0] bitlen;
    } vec_t;

    vec_t vt[10];
    int   base;
    int   a1, p1, p2;

    initial begin
        vt[0] = '{1,   1'b0, 1, 64'd8};
        vt[1] = '{2,   1'b0, 1, 64'd16};
        vt[2] = '{4,   1'b0, 1, 64'd32};
        vt[3] = '{55,  1'b0, 1, 64'd440};
        vt[4] = '{60,  1'b1, 2, 64'd480};
        vt[5] = '{63,  1'b0, 2, 64'd504};
        vt[6] = '{120, 1'b1, 3, 64'd960};
        vt[7] = '{127, 1'b0, 3, 64'd1016};
        vt[8] = '{128, 1'b1, 3, 64'd1024};
        vt[9] = '{9,   1'b1, 1, 64'd72};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        in_bytes = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready",  512'(in_ready),  512'(1));
        check("rst_blk_valid", 512'(blk_valid), 512'(0));
        check("rst_blk_last",  512'(blk_last),  512'(0));
        check("rst_blk_mode",  512'(blk_mode),  512'(0));
        check("rst_blk_msg",   blk_message,     512'(0));

        // "abc": single block, 2-cycle latency
        load_abc();
        ref_pad();
        base = got.size();
        send(1'b0, 100);
        a1 = last_acc;
        wait_blocks("abc", base, 1);
        if (got.size() > base) begin
            check("abc_word0",   512'(got[base].msg[511:480]), 512'(32'h6162_6380));
            check("abc_mid",     512'(got[base].msg[479:32]),  512'(0));
            check("abc_word15",  512'(got[base].msg[31:0]),    512'(32'h0000_0018));
            check("abc_latency", 512'(got[base].cyc - a1),     512'(2));
        end
        check_blocks("abc", base);

        // 56 bytes: marker in word 14, length-only second block 64 cycles later
        build(56);
        ref_pad();
        base = got.size();
        send(1'b0, 100);
        wait_blocks("m56", base, 2);
        if (got.size() > base + 1) begin
            check("m56_b1_w14", 512'(got[base].msg[63:32]),    512'(32'h8000_0000));
            check("m56_b1_w15", 512'(got[base].msg[31:0]),     512'(0));
            check("m56_b2_hi",  512'(got[base+1].msg[511:32]), 512'(0));
            check("m56_b2_w15", 512'(got[base+1].msg[31:0]),   512'(32'h0000_01C0));
            check("m56_gap",    512'(got[base+1].cyc - got[base].cyc), 512'(BI));
        end
        check_blocks("m56", base);

        // 64 bytes: data block unaltered, then marker + length block
        build(64);
        ref_pad();
        base = got.size();
        send(1'b0, 100);
        wait_blocks("m64", base, 2);
        if (got.size() > base + 1) begin
            check("m64_b2_w0",  512'(got[base+1].msg[511:480]), 512'(32'h8000_0000));
            check("m64_b2_mid", 512'(got[base+1].msg[479:32]),  512'(0));
            check("m64_b2_w15", 512'(got[base+1].msg[31:0]),    512'(32'h0000_0200));
        end
        check_blocks("m64", base);

        for (int v = 0; v < 10; v++) begin
            build(vt[v].len);
            ref_pad();
            base = got.size();
            send(vt[v].gaps, 100);
            wait_blocks($sformatf("vec%0d", v), base, vt[v].nblk);
            if (got.size() >= base + vt[v].nblk)
                check($sformatf("vec%0d_bitlen", v),
                      512'(got[base + vt[v].nblk - 1].msg[63:0]), 512'(vt[v].bitlen));
            check_blocks($sformatf("vec%0d", v), base);
        end

        // Back-to-back "abc": second beat held until the first pulse
        load_abc();
        ref_pad();
        base = got.size();
        send(1'b0, 100);
        send(1'b0, 100);
        wait_blocks("b2b", base, 2);
        if (got.size() > base + 1) begin
            p1 = got[base].cyc;
            p2 = got[base+1].cyc;
            check("b2b_held_until_pulse", 512'(last_acc), 512'(p1 + 1));
            check("b2b_gap",   512'(p2 - p1), 512'(BI));
            check("b2b_mode2", 512'(got[base+1].mode), 512'(1));
            check("b2b_last2", 512'(got[base+1].last), 512'(1));
            check("b2b_msg2",  got[base+1].msg, exp_blks[0]);
        end

        // Reset after 5 beats of a longer message, then "abc"
        build(100);
        send(1'b0, 5);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_cyc = -1;
        load_abc();
        ref_pad();
        base = got.size();
        send(1'b0, 100);
        a1 = last_acc;
        wait_blocks("rst_abc", base, 1);
        if (got.size() > base)
            check("rst_abc_latency", 512'(got[base].cyc - a1), 512'(2));
        check_blocks("rst_abc", base);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
